hs_tx_lane_sequencer: RTL and testbench

HS transmit lane sequencer for the MIPI D-PHY TX datapath. It drives the DDR output flip-flop stage (Enable, Serial_B1, Serial_B2) and the LP line drivers. It walks the lane through the LP-11 → LP-01 → LP-00 → HS-zero → sync → payload → trail → LP-11 burst sequence, and serializes payload bytes two bits per TX_DDR_clk cycle. It sits between the byte-level packet source and the DDR output stage.

---
 rtl/mipi_dphy_tx_pkg.sv | 24 ++
 rtl/hs_tx_byte_shifter.sv | 48 ++++
 rtl/hs_tx_lane_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_hs_tx_lane_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_dphy_tx_pkg.sv
// Shared types and constants for the D-PHY HS transmit lane sequencer.
package mipi_dphy_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LPX,
        ST_PREP,
        ST_HS_ZERO,
        ST_SYNC,
        ST_DATA,
        ST_TRAIL,
        ST_EXIT
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // LP line codes as {LP_Dp, LP_Dn}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    localparam int unsigned BYTE_CNT_W = 16;

endpackage

// File: rtl/hs_tx_byte_shifter.sv
// Byte holding register with 2-bit pair index; exposes the pair to be driven next cycle.
module hs_tx_byte_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       advance,
    output logic       pair_b1_nxt,
    output logic       pair_b2_nxt,
    output logic       last_pair_nxt,
    output logic       last_pair,
    output logic       last_bit
);

    logic [7:0] data_q;
    logic [7:0] data_d;
    logic [1:0] idx_q;
    logic [1:0] idx_d;

    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        if (load) begin
            data_d = load_data;
            idx_d  = 2'd0;
        end else if (advance) begin
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= 8'd0;
            idx_q  <= 2'd0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
        end
    end

    assign pair_b1_nxt   = data_d[{idx_d, 1'b0}];
    assign pair_b2_nxt   = data_d[{idx_d, 1'b1}];
    assign last_pair_nxt = (idx_d == 2'd3);
    assign last_pair     = (idx_q == 2'd3);
    // B2 of the pair currently on the wire
    assign last_bit      = data_q[{idx_q, 1'b1}];

endmodule

// File: rtl/hs_tx_lane_sequencer.sv
// D-PHY HS transmit lane sequencer: LP entry, HS-zero, sync, payload, trail, LP exit.
// Optional HS_TX_SEQ_BYTECNT_EN adds a saturating per-burst Byte_count output.
module hs_tx_lane_sequencer
    import mipi_dphy_tx_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned T_LPX        = 2,
    parameter int unsigned T_HS_PREPARE = 3,
    parameter int unsigned T_HS_ZERO    = 4,
    parameter int unsigned T_HS_TRAIL   = 3,
    parameter int unsigned T_HS_EXIT    = 2
) (
    input  logic       TX_DDR_clk,
    input  logic       TX_rst,
    input  logic       TX_req_HS,
    input  logic [7:0] TX_data,
    input  logic       TX_valid,
    output logic       TX_ready,
    output logic       Enable,
    output logic       Serial_B1,
    output logic       Serial_B2,
    output logic       LP_Dp,
    output logic       LP_Dn,
    output logic       HS_active
`ifdef HS_TX_SEQ_BYTECNT_EN
    ,
    output logic [BYTE_CNT_W-1:0] Byte_count
`endif
);

    tx_state_t        state_q;
    tx_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic       sh_load;
    logic [7:0] sh_data;
    logic       sh_adv;
    logic       pair_b1_nxt;
    logic       pair_b2_nxt;
    logic       last_pair_nxt;
    logic       last_pair;
    logic       last_bit;

    logic       enable_d;
    logic       b1_d;
    logic       b2_d;
    logic [1:0] lp_d;
    logic       ready_d;

    hs_tx_byte_shifter u_shifter (
        .clk           (TX_DDR_clk),
        .rst           (TX_rst),
        .load          (sh_load),
        .load_data     (sh_data),
        .advance       (sh_adv),
        .pair_b1_nxt   (pair_b1_nxt),
        .pair_b2_nxt   (pair_b2_nxt),
        .last_pair_nxt (last_pair_nxt),
        .last_pair     (last_pair),
        .last_bit      (last_bit)
    );

    // Next state plus the output values that go with it, so every output is a flop
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_load = 1'b0;
        sh_data = SYNC_BYTE;
        sh_adv  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (TX_req_HS) begin
                    state_d = ST_LPX;
                    cnt_d   = CNT_W'(T_LPX - 1);
                end
            end
            ST_LPX: begin
                if (cnt_q == '0) begin
                    state_d = ST_PREP;
                    cnt_d   = CNT_W'(T_HS_PREPARE - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PREP: begin
                if (cnt_q == '0) begin
                    state_d = ST_HS_ZERO;
                    cnt_d   = CNT_W'(T_HS_ZERO - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HS_ZERO: begin
                if (cnt_q == '0) begin
                    state_d = ST_SYNC;
                    sh_load = 1'b1;
                    sh_data = SYNC_BYTE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SYNC, ST_DATA: begin
                // Byte boundary: a missing byte ends the burst
                if (last_pair) begin
                    if (TX_valid) begin
                        state_d = ST_DATA;
                        sh_load = 1'b1;
                        sh_data = TX_data;
                    end else begin
                        state_d = ST_TRAIL;
                        cnt_d   = CNT_W'(T_HS_TRAIL - 1);
                    end
                end else begin
                    sh_adv = 1'b1;
                end
            end
            ST_TRAIL: begin
                if (cnt_q == '0) begin
                    state_d = ST_EXIT;
                    cnt_d   = CNT_W'(T_HS_EXIT - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EXIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        enable_d = (state_d == ST_HS_ZERO) || (state_d == ST_SYNC) ||
                   (state_d == ST_DATA)    || (state_d == ST_TRAIL);
        ready_d  = ((state_d == ST_SYNC) || (state_d == ST_DATA)) && last_pair_nxt;

        b1_d = 1'b0;
        b2_d = 1'b0;
        if ((state_d == ST_SYNC) || (state_d == ST_DATA)) begin
            b1_d = pair_b1_nxt;
            b2_d = pair_b2_nxt;
        end else if (state_d == ST_TRAIL) begin
            b1_d = ~last_bit;
            b2_d = ~last_bit;
        end

        if ((state_d == ST_IDLE) || (state_d == ST_EXIT)) begin
            lp_d = LP11;
        end else if (state_d == ST_LPX) begin
            lp_d = LP01;
        end else begin
            lp_d = LP00;
        end
    end

    always_ff @(posedge TX_DDR_clk) begin
        if (TX_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            TX_ready  <= 1'b0;
            Enable    <= 1'b0;
            HS_active <= 1'b0;
            Serial_B1 <= 1'b0;
            Serial_B2 <= 1'b0;
            LP_Dp     <= 1'b1;
            LP_Dn     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            TX_ready  <= ready_d;
            Enable    <= enable_d;
            HS_active <= enable_d;
            Serial_B1 <= b1_d;
            Serial_B2 <= b2_d;
            LP_Dp     <= lp_d[1];
            LP_Dn     <= lp_d[0];
        end
    end

`ifdef HS_TX_SEQ_BYTECNT_EN
    logic                  byte_accept;
    logic [BYTE_CNT_W-1:0] byte_cnt_q;

    assign byte_accept = ((state_q == ST_SYNC) || (state_q == ST_DATA)) && last_pair && TX_valid;

    // Cleared on SYNC entry, saturating, held after the burst
    always_ff @(posedge TX_DDR_clk) begin
        if (TX_rst) begin
            byte_cnt_q <= '0;
        end else if ((state_d == ST_SYNC) && (state_q != ST_SYNC)) begin
            byte_cnt_q <= '0;
        end else if (byte_accept && (byte_cnt_q != {BYTE_CNT_W{1'b1}})) begin
            byte_cnt_q <= byte_cnt_q + BYTE_CNT_W'(1);
        end
    end

    assign Byte_count = byte_cnt_q;
`endif

endmodule

// File: tb/tb_hs_tx_lane_sequencer.sv
// Self-checking bench: a per-cycle expected trace is built from the burst rules, then replayed.
module tb_hs_tx_lane_sequencer;
    import mipi_dphy_tx_pkg::*;

    localparam int unsigned T_LPX_P   = 2;
    localparam int unsigned T_PREP_P  = 3;
    localparam int unsigned T_ZERO_P  = 4;
    localparam int unsigned T_TRAIL_P = 3;
    localparam int unsigned T_EXIT_P  = 2;

    // Observed vector layout: {LP_Dp, LP_Dn, Enable, HS_active, Serial_B1, Serial_B2, TX_ready}
    localparam logic [6:0] V_IDLE = 7'b1100000;
    localparam logic [6:0] V_LPX  = 7'b0100000;
    localparam logic [6:0] V_PREP = 7'b0000000;
    localparam logic [6:0] V_ZERO = 7'b0011000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [7:0]  data = 8'd0;
    logic        valid = 1'b0;
    logic        ready, enable, b1, b2, lp_dp, lp_dn, hs_active;
    logic [15:0] byte_count;
    logic [6:0]  obs;

    typedef struct {
        logic [6:0]  exp;
        logic        req;
        logic        valid;
        logic [7:0]  data;
        logic [15:0] bc;
    } cyc_t;

    cyc_t        model_q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] prev_bc = 16'd0;

    always #5 clk = ~clk;

    assign obs = {lp_dp, lp_dn, enable, hs_active, b1, b2, ready};

    hs_tx_lane_sequencer #(
        .CNT_W        (8),
        .T_LPX        (T_LPX_P),
        .T_HS_PREPARE (T_PREP_P),
        .T_HS_ZERO    (T_ZERO_P),
        .T_HS_TRAIL   (T_TRAIL_P),
        .T_HS_EXIT    (T_EXIT_P)
    ) dut (
        .TX_DDR_clk (clk),
        .TX_rst     (rst),
        .TX_req_HS  (req),
        .TX_data    (data),
        .TX_valid   (valid),
        .TX_ready   (ready),
        .Enable     (enable),
        .Serial_B1  (b1),
        .Serial_B2  (b2),
        .LP_Dp      (lp_dp),
        .LP_Dn      (lp_dn),
        .HS_active  (hs_active)
`ifdef HS_TX_SEQ_BYTECNT_EN
        ,
        .Byte_count (byte_count)
`endif
    );

`ifndef HS_TX_SEQ_BYTECNT_EN
    assign byte_count = 16'd0;
`endif

    function automatic logic nz(input bit noisy);
        return noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    function automatic void add(input logic [6:0] e, input logic r, input logic v,
                                input logic [7:0] d, input logic [15:0] bc);
        cyc_t c;
        c.exp = e; c.req = r; c.valid = v; c.data = d; c.bc = bc;
        model_q.push_back(c);
    endfunction

    // Expected trace of one burst starting with the request in cycle 0
    function automatic void build(input logic [7:0] b[$], input bit noisy);
        logic [7:0]  stream[$];
        logic [7:0]  cur;
        logic [7:0]  last_byte;
        logic        tb;
        logic [15:0] bc;
        int          n;
        model_q.delete();
        n  = b.size();
        bc = prev_bc;
        add(V_IDLE, 1'b1, nz(noisy), 8'($urandom), bc);
        for (int i = 0; i < int'(T_LPX_P); i++)  add(V_LPX,  nz(noisy), nz(noisy), 8'($urandom), bc);
        for (int i = 0; i < int'(T_PREP_P); i++) add(V_PREP, nz(noisy), nz(noisy), 8'($urandom), bc);
        for (int i = 0; i < int'(T_ZERO_P); i++) add(V_ZERO, nz(noisy), nz(noisy), 8'($urandom), bc);
        stream.push_back(SYNC_BYTE);
        foreach (b[i]) stream.push_back(b[i]);
        for (int j = 0; j < stream.size(); j++) begin
            cur = stream[j];
            bc  = 16'(j);
            for (int k = 0; k < 4; k++) begin
                if (k == 3)
                    add({4'b0011, cur[2*k], cur[2*k+1], 1'b1}, nz(noisy), (j < n),
                        (j < n) ? b[j] : 8'($urandom), bc);
                else
                    add({4'b0011, cur[2*k], cur[2*k+1], 1'b0}, nz(noisy), nz(noisy),
                        8'($urandom), bc);
            end
        end
        bc        = 16'(n);
        last_byte = stream[stream.size()-1];
        tb        = ~last_byte[7];
        for (int i = 0; i < int'(T_TRAIL_P); i++) add({4'b0011, tb, tb, 1'b0}, nz(noisy), nz(noisy), 8'($urandom), bc);
        for (int i = 0; i < int'(T_EXIT_P); i++)  add(V_IDLE, nz(noisy), nz(noisy), 8'($urandom), bc);
        add(V_IDLE, 1'b0, nz(noisy), 8'($urandom), bc);
        prev_bc = bc;
    endfunction

    // Replay model_q: compare outputs of cycle k at negedge, then drive inputs for cycle k
    task automatic run(input string name, input int limit);
        for (int k = 0; k < model_q.size() && (limit < 0 || k < limit); k++) begin
            @(negedge clk);
            total++;
            if (obs !== model_q[k].exp) begin
                bad++;
                $display("FAIL %s cycle %0d: outputs got %b expected %b", name, k, obs, model_q[k].exp);
            end
`ifdef HS_TX_SEQ_BYTECNT_EN
            total++;
            if (byte_count !== model_q[k].bc) begin
                bad++;
                $display("FAIL %s cycle %0d: Byte_count got %0d expected %0d", name, k, byte_count, model_q[k].bc);
            end
`endif
            req   = model_q[k].req;
            valid = model_q[k].valid;
            data  = model_q[k].data;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (obs !== V_IDLE || byte_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_values: got %b/%0d expected %b/0", obs, byte_count, V_IDLE);
        end
        rst = 1'b0;
        prev_bc = 16'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            valid = 1'($urandom_range(0, 1));
            data  = 8'($urandom);
            total++;
            if (obs !== V_IDLE) begin
                bad++;
                $display("FAIL idle cycle %0d: got %b expected %b", i, obs, V_IDLE);
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_empty_burst();
        logic [7:0] q[$];
        q = {};
        build(q, 1'b0);
        run("empty_burst", -1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        q = {8'hA5, 8'h3C};
        build(q, 1'b0);
        run("back_to_back", -1);
    endtask

    task automatic test_gap_late_valid();
        logic [7:0] q[$];
        q = {8'hFF};
        build(q, 1'b0);
        foreach (model_q[i]) if (!model_q[i].exp[0]) model_q[i].valid = 1'b1;
        run("gap_late_valid", -1);
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        for (int r = 0; r < 8; r++) begin
            q = {};
            for (int i = 0; i < int'($urandom_range(0, 6)); i++) q.push_back(8'($urandom));
            build(q, 1'b1);
            run("random_burst", -1);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] q[$];
        q = {8'h5A, 8'hC3, 8'h0F};
        build(q, 1'b0);
        run("pre_reset", 16);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== V_IDLE || byte_count !== 16'd0) begin
            bad++;
            $display("FAIL mid_burst_reset: got %b/%0d expected %b/0", obs, byte_count, V_IDLE);
        end
        rst = 1'b0; req = 1'b0; valid = 1'b0;
        prev_bc = 16'd0;
        q = {8'h81};
        build(q, 1'b0);
        run("restart_after_reset", -1);
    endtask

    task automatic test_byte_count();
        logic [7:0] q[$];
        q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        build(q, 1'b1);
        run("bytecnt_five", -1);
        q = {};
        build(q, 1'b0);
        run("bytecnt_clear", -1);
    endtask

    initial begin
        test_reset();
        test_empty_burst();
        test_back_to_back();
        test_gap_late_valid();
        test_random();
        test_reset_mid_burst();
        test_byte_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
